// File: rtl/fifo_wr_arbiter_pkg.sv
// fifo_arb_pkg: shared defaults and state encoding for the FIFO write arbiter
package fifo_arb_pkg;

    typedef logic [7:0] data_t;

    localparam int N_REQ_DEF     = 4;
    localparam int MAX_BURST_DEF = 4;

    typedef enum logic {IDLE, BURST} state_e;

endpackage

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// rr_picker: rotating first-set search over req starting at start_idx
module rr_picker #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] start_idx,
    output logic [IW-1:0] sel,
    output logic          any
);

    // scan from farthest to nearest so the nearest set bit wins
    always_comb begin
        sel = start_idx;
        for (int k = N - 1; k >= 0; k--)
            if (req[(int'(start_idx) + k) % N]) sel = IW'((int'(start_idx) + k) % N);
        any = |req;
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter sharing one FIFO write port
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int  N_REQ     = N_REQ_DEF,
    parameter type DATA_T    = data_t,
    parameter int  MAX_BURST = MAX_BURST_DEF
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [N_REQ-1:0]           req,
    input  DATA_T [N_REQ-1:0]          data,
    output logic [N_REQ-1:0]           gnt,
    output logic [N_REQ-1:0]           stall,
    output logic                       fifo_w_req,
    output DATA_T                      fifo_w_data,
    input  logic                       fifo_w_stall,
    output logic [$clog2(N_REQ)-1:0]   owner,
    output logic                       busy
);

    localparam int IW = $clog2(N_REQ);
    localparam int CW = $clog2(MAX_BURST + 1);

    state_e          state_q;
    logic [IW-1:0]   rr_q;
    logic [IW-1:0]   owner_q;
    logic [CW-1:0]   cnt_q;
    logic [IW-1:0]   pick_sel;
    logic            pick_any;
    logic [IW-1:0]   sel;
    logic            owner_hold;
    logic            accept;

    function automatic logic [IW-1:0] wrap(input logic [IW-1:0] x);
        return (x == IW'(N_REQ - 1)) ? '0 : x + 1'b1;
    endfunction

    // a dropped owner hands over in the same cycle, searching past itself
    rr_picker #(.N(N_REQ), .IW(IW)) u_pick (
        .req       (req),
        .start_idx ((state_q == BURST) ? wrap(owner_q) : rr_q),
        .sel       (pick_sel),
        .any       (pick_any)
    );

    assign owner_hold  = (state_q == BURST) && req[owner_q];
    assign sel         = owner_hold ? owner_q : pick_sel;
    assign fifo_w_req  = reset_n && pick_any;
    assign fifo_w_data = fifo_w_req ? data[sel] : '0;
    assign accept      = fifo_w_req && !fifo_w_stall;
    assign gnt         = {{(N_REQ-1){1'b0}}, accept} << sel;
    assign stall       = req & ~gnt;
    assign owner       = owner_q;
    assign busy        = (state_q == BURST);

    // burst FSM; everything holds on back-pressure or when nobody requests
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            rr_q    <= '0;
            owner_q <= '0;
            cnt_q   <= '0;
        end else if (accept) begin
            if (owner_hold) begin
                cnt_q <= cnt_q + 1'b1;
                if (cnt_q == CW'(MAX_BURST - 1)) begin
                    state_q <= IDLE;
                    rr_q    <= wrap(owner_q);
                end
            end else if (MAX_BURST > 1) begin
                state_q <= BURST;
                owner_q <= sel;
                cnt_q   <= CW'(1);
                rr_q    <= (state_q == BURST) ? wrap(owner_q) : rr_q;
            end else begin
                state_q <= IDLE;
                rr_q    <= wrap(sel);
            end
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed checks of burst arbitration, reset, back-pressure and wrap
module tb_fifo_wr_arbiter;

    logic             clk;
    logic             reset_n;
    logic [3:0]       req_a;
    logic [3:0][7:0]  data_a;
    logic [3:0]       gnt_a;
    logic [3:0]       stall_a;
    logic             fwr_a;
    logic [7:0]       fwd_a;
    logic             fst_a;
    logic [1:0]       owner_a;
    logic             busy_a;

    logic [2:0]       req_b;
    logic [2:0][7:0]  data_b;
    logic [2:0]       gnt_b;
    logic [2:0]       stall_b;
    logic             fwr_b;
    logic [7:0]       fwd_b;
    logic             fst_b;
    logic [1:0]       owner_b;
    logic             busy_b;

    int n_cmp = 0;
    int n_err = 0;

    logic [3:0] g39 [9] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001,
                            4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0001};
    logic [8:0] b39 = 9'b011101110;

    fifo_wr_arbiter #(.N_REQ(4), .MAX_BURST(4)) dut_a (
        .clk(clk), .reset_n(reset_n), .req(req_a), .data(data_a), .gnt(gnt_a),
        .stall(stall_a), .fifo_w_req(fwr_a), .fifo_w_data(fwd_a),
        .fifo_w_stall(fst_a), .owner(owner_a), .busy(busy_a)
    );

    fifo_wr_arbiter #(.N_REQ(3), .MAX_BURST(1)) dut_b (
        .clk(clk), .reset_n(reset_n), .req(req_b), .data(data_b), .gnt(gnt_b),
        .stall(stall_b), .fifo_w_req(fwr_b), .fifo_w_data(fwd_b),
        .fifo_w_stall(fst_b), .owner(owner_b), .busy(busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        reset_n = 1'b0;
        #1;
        cyc();
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0;
        fst_a   = 1'b0;
        fst_b   = 1'b0;
        data_a  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        data_b  = {8'hB2, 8'hB1, 8'hB0};
        req_a   = 4'b1111;
        req_b   = 3'b111;
        @(negedge clk);
        chk("rst_gnt", gnt_a, 4'b0000);
        chk("rst_wreq", fwr_a, 1'b0);
        chk("rst_busy", busy_a, 1'b0);
        chk("rst_owner", owner_a, 2'd0);
        chk("rst_gnt_b", gnt_b, 3'b000);
        cyc();
        reset_n = 1'b1;
        req_b   = 3'b000;
        @(negedge clk);
        chk("first_gnt", gnt_a, 4'b0001);
        chk("first_data", fwd_a, 8'hA0);
        cyc();
        chk("first_busy", busy_a, 1'b1);
        reset_n = 1'b0;
        #1;
        chk("midrst_busy", busy_a, 1'b0);
        chk("midrst_owner", owner_a, 2'd0);
        chk("midrst_gnt", gnt_a, 4'b0000);
        chk("midrst_wreq", fwr_a, 1'b0);
        cyc();
        reset_n = 1'b1;

        req_a = 4'b0011;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            chk($sformatf("burst_gnt%0d", i), gnt_a, g39[i]);
            chk($sformatf("burst_busy%0d", i), busy_a, b39[i]);
            chk($sformatf("burst_data%0d", i), fwd_a, (g39[i] == 4'b0001) ? 8'hA0 : 8'hA1);
            chk($sformatf("burst_stall%0d", i), stall_a, 4'b0011 & ~g39[i]);
            cyc();
        end

        pulse_reset();
        req_a = 4'b1100;
        @(negedge clk);
        chk("early_gnt1", gnt_a, 4'b0100);
        cyc();
        @(negedge clk);
        chk("early_gnt2", gnt_a, 4'b0100);
        chk("early_owner2", owner_a, 2'd2);
        cyc();
        req_a = 4'b1000;
        @(negedge clk);
        chk("early_gnt3", gnt_a, 4'b1000);
        chk("early_busy3", busy_a, 1'b1);
        chk("early_data3", fwd_a, 8'hA3);
        cyc();
        chk("early_owner3", owner_a, 2'd3);
        chk("early_busy4", busy_a, 1'b1);
        req_a = 4'b0111;
        @(negedge clk);
        chk("early_next", gnt_a, 4'b0001);
        cyc();

        pulse_reset();
        req_a = 4'b0010;
        @(negedge clk);
        chk("bp_gnt1", gnt_a, 4'b0010);
        cyc();
        @(negedge clk);
        chk("bp_gnt2", gnt_a, 4'b0010);
        cyc();
        req_a = 4'b0011;
        fst_a = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("bp_gnt_s%0d", i), gnt_a, 4'b0000);
            chk($sformatf("bp_stall_s%0d", i), stall_a, 4'b0011);
            chk($sformatf("bp_wreq_s%0d", i), fwr_a, 1'b1);
            chk($sformatf("bp_data_s%0d", i), fwd_a, 8'hA1);
            chk($sformatf("bp_owner_s%0d", i), owner_a, 2'd1);
            chk($sformatf("bp_busy_s%0d", i), busy_a, 1'b1);
            cyc();
        end
        fst_a = 1'b0;
        @(negedge clk);
        chk("bp_rel1", gnt_a, 4'b0010);
        cyc();
        @(negedge clk);
        chk("bp_rel2", gnt_a, 4'b0010);
        cyc();
        @(negedge clk);
        chk("bp_rel3", gnt_a, 4'b0001);
        chk("bp_rel3_busy", busy_a, 1'b0);
        cyc();

        req_b = 3'b111;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk($sformatf("wrap_gnt%0d", i), gnt_b, 3'b001 << (i % 3));
            chk($sformatf("wrap_data%0d", i), fwd_b, 8'hB0 + 8'(i % 3));
            chk($sformatf("wrap_busy%0d", i), busy_b, 1'b0);
            cyc();
        end
        req_b = 3'b000;

        req_a = 4'b0000;
        @(negedge clk);
        chk("idle_wreq", fwr_a, 1'b0);
        chk("idle_gnt", gnt_a, 4'b0000);
        chk("idle_data", fwd_a, 8'h00);
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
